// File: rtl/mst_imp_dma.sv
// mst_imp_dma: AXI-Lite master copying a 2-D rectangle of beats from src to dst.
// Ports: clk/PoR_rst_n; start + geometry/address config in; busy/done/err out;
//   AR/R read channel and AW/W/B write channel (AXI-Lite, one beat per transfer).
module mst_imp_dma #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_W      = 8
) (
  input  logic                clk,
  input  logic                PoR_rst_n,
  input  logic                start,
  input  logic [DIM_W-1:0]    hsize,
  input  logic [DIM_W-1:0]    vsize,
  input  logic [DIM_W-1:0]    src_minx,
  input  logic [DIM_W-1:0]    src_miny,
  input  logic [DIM_W-1:0]    dst_minx,
  input  logic [DIM_W-1:0]    dst_miny,
  input  logic [ADDR_W-1:0]   src_baddr,
  input  logic [ADDR_W-1:0]   dst_baddr,
  input  logic [ADDR_W-1:0]   src_pitch,
  input  logic [ADDR_W-1:0]   dst_pitch,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_prot,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_prot,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  localparam int BYTES = DATA_W / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_n;

  logic [DIM_W-1:0]  hs_q, vs_q;
  logic [DIM_W-1:0]  sx_q, sy_q, dx_q, dy_q;
  logic [ADDR_W-1:0] sb_q, db_q, sp_q, dp_q;

  logic [DIM_W-1:0]  rx, ry, wx, wy;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     fcnt;
  // reads in flight plus FIFO occupancy; gates AR issue
  logic [CW-1:0]     cred;

  // act: current write beat still has AW or W pending
  logic act, aw_ok, w_ok, b_wait;

  logic accept, zero;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic issue, beat, both_done;
  logic rx_last, ry_last, wx_last, wy_last;
  logic last_ar, last_b;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] pitch,
    input logic [DIM_W-1:0]  mx,
    input logic [DIM_W-1:0]  my,
    input logic [DIM_W-1:0]  x,
    input logic [DIM_W-1:0]  y
  );
    logic [ADDR_W-1:0] row, col;
    row = ADDR_W'({1'b0, my} + {1'b0, y});
    col = ADDR_W'({1'b0, mx} + {1'b0, x});
    return base + row * pitch + col * ADDR_W'(BYTES);
  endfunction

  assign accept = start && (state == IDLE);
  assign zero   = (hsize == '0) || (vsize == '0);

  assign busy    = (state != IDLE);
  assign r_ready = busy;
  assign b_ready = b_wait;
  assign ar_prot = 3'b000;
  assign aw_prot = 3'b000;
  assign w_strb  = '1;

  assign ar_valid = (state == RUN) && (cred < CW'(FIFO_DEPTH));
  assign ar_addr  = beat_addr(sb_q, sp_q, sx_q, sy_q, rx, ry);
  assign aw_addr  = beat_addr(db_q, dp_q, dx_q, dy_q, wx, wy);

  // a new write beat starts straight off a non-empty FIFO
  assign issue    = busy && !act && !b_wait && (fcnt != '0);
  assign beat     = issue || act;
  assign aw_valid = beat && !aw_ok;
  assign w_valid  = beat && !w_ok;
  assign w_data   = mem[rp];

  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_valid && r_ready;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign b_hs  = b_valid && b_ready;

  assign both_done = beat && (aw_ok || aw_hs) && (w_ok || w_hs);

  assign rx_last = (rx == hs_q - DIM_W'(1));
  assign ry_last = (ry == vs_q - DIM_W'(1));
  assign wx_last = (wx == hs_q - DIM_W'(1));
  assign wy_last = (wy == vs_q - DIM_W'(1));
  assign last_ar = ar_hs && rx_last && ry_last;
  assign last_b  = b_hs && wx_last && wy_last;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start && !zero) state_n = RUN;
      RUN:     if (last_ar) state_n = FLUSH;
      FLUSH:   if (last_b) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      hs_q <= '0; vs_q <= '0;
      sx_q <= '0; sy_q <= '0;
      dx_q <= '0; dy_q <= '0;
      sb_q <= '0; db_q <= '0;
      sp_q <= '0; dp_q <= '0;
    end else if (accept) begin
      hs_q <= hsize;     vs_q <= vsize;
      sx_q <= src_minx;  sy_q <= src_miny;
      dx_q <= dst_minx;  dy_q <= dst_miny;
      sb_q <= src_baddr; db_q <= dst_baddr;
      sp_q <= src_pitch; dp_q <= dst_pitch;
    end
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      rx <= '0; ry <= '0;
      wx <= '0; wy <= '0;
    end else if (accept) begin
      rx <= '0; ry <= '0;
      wx <= '0; wy <= '0;
    end else begin
      if (ar_hs) begin
        if (rx_last) begin
          rx <= '0;
          ry <= ry + DIM_W'(1);
        end else begin
          rx <= rx + DIM_W'(1);
        end
      end
      if (b_hs) begin
        if (wx_last) begin
          wx <= '0;
          wy <= wy + DIM_W'(1);
        end else begin
          wx <= wx + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) mem[wp] <= r_data;
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
      cred <= '0;
    end else begin
      if (r_hs) wp <= wp + PW'(1);
      if (w_hs) rp <= rp + PW'(1);
      fcnt <= fcnt + CW'(r_hs) - CW'(w_hs);
      cred <= cred + CW'(ar_hs) - CW'(w_hs);
    end
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      act    <= 1'b0;
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      b_wait <= 1'b0;
    end else if (accept) begin
      act    <= 1'b0;
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      b_wait <= 1'b0;
    end else begin
      act <= beat && !both_done;
      if (both_done) begin
        aw_ok  <= 1'b0;
        w_ok   <= 1'b0;
        b_wait <= 1'b1;
      end else begin
        aw_ok <= aw_ok || aw_hs;
        w_ok  <= w_ok || w_hs;
        if (b_hs) b_wait <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      if (accept)
        err <= 1'b0;
      else if ((r_hs && r_resp != 2'b00) ||
               (b_hs && b_resp != 2'b00))
        err <= 1'b1;
      done <= (state == FLUSH && last_b) ||
              (accept && zero);
    end
  end

endmodule

// File: tb/tb_mst_imp_dma.sv
// tb_mst_imp_dma: randomized AXI-Lite slave plus raster reference model.
// Checks addresses, data, handshake stability, occupancy, err and done.
module tb_mst_imp_dma;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int DIMW  = 8;

  logic            clk, PoR_rst_n, start;
  logic [DIMW-1:0] hsize, vsize;
  logic [DIMW-1:0] src_minx, src_miny, dst_minx, dst_miny;
  logic [AW-1:0]   src_baddr, dst_baddr, src_pitch, dst_pitch;
  logic            busy, done, err;
  logic            ar_valid, ar_ready, r_valid, r_ready;
  logic [AW-1:0]   ar_addr, aw_addr;
  logic [2:0]      ar_prot, aw_prot;
  logic [DW-1:0]   r_data, w_data;
  logic [1:0]      r_resp, b_resp;
  logic            aw_valid, aw_ready, w_valid, w_ready;
  logic [DW/8-1:0] w_strb;
  logic            b_valid, b_ready;

  mst_imp_dma #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .DIM_W(DIMW)
  ) dut (
    .clk(clk), .PoR_rst_n(PoR_rst_n), .start(start),
    .hsize(hsize), .vsize(vsize),
    .src_minx(src_minx), .src_miny(src_miny),
    .dst_minx(dst_minx), .dst_miny(dst_miny),
    .src_baddr(src_baddr), .dst_baddr(dst_baddr),
    .src_pitch(src_pitch), .dst_pitch(dst_pitch),
    .busy(busy), .done(done), .err(err),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_addr(aw_addr), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_addr(
    input logic [31:0] base, input logic [31:0] pitch,
    input int mx, input int my, input int x, input int y);
    return base + 32'(my + y) * pitch + 32'(mx + x) * 32'd4;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] exp_ar[$], exp_aw[$], exp_w[$];
  int cyc = 0;
  int bp_en = 0, rd_lat = 1, err_beat = -1, beat_b = 0;
  int n_ar = 0, n_w = 0, n_aw = 0, n_b = 0, b_pend = 0;
  int done_cnt = 0, d0 = 0, job_err = 0;
  bit aw_got = 0, w_got = 0, first_r = 0, first_ar_pend = 0;
  bit chk_aw_next = 0, chk_err_next = 0;
  bit hold_ar = 0, hold_aw = 0, hold_w = 0;
  logic [31:0] hold_ar_a, hold_aw_a, hold_w_d, first_ar;

  // slave: decide inputs on the falling edge, handshakes land on the next rise
  initial begin
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    first_ar = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!PoR_rst_n) begin
        rq.delete();
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        n_ar = 0; n_w = 0; n_aw = 0; n_b = 0; b_pend = 0;
        aw_got = 0; w_got = 0;
        hold_ar = 0; hold_aw = 0; hold_w = 0;
        chk_aw_next = 0; chk_err_next = 0;
        ar_ready = 0; r_valid = 0; aw_ready = 0;
        w_ready = 0; b_valid = 0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("busy_at_done", 64'(busy), 64'(0));
        end
        if (hold_ar)
          chk("ar_hold", 64'({ar_valid, ar_addr}),
              64'({1'b1, hold_ar_a}));
        if (hold_aw)
          chk("aw_hold", 64'({aw_valid, aw_addr}),
              64'({1'b1, hold_aw_a}));
        if (hold_w)
          chk("w_hold", 64'({w_valid, w_data}),
              64'({1'b1, hold_w_d}));
        if (chk_aw_next) begin
          chk("aw_lat", 64'(aw_valid), 64'(1));
          chk_aw_next = 0;
        end
        if (chk_err_next) begin
          chk("err_set", 64'(err), 64'(1));
          chk_err_next = 0;
        end
        if (busy) begin
          chk("occ", 64'((n_ar - n_w) <= DEPTH), 64'(1));
          chk("wr_fly", 64'((n_aw - n_b) <= 1), 64'(1));
        end

        ar_ready = bp_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        aw_ready = bp_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        w_ready  = bp_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          r_valid = 1'b1;
          r_data  = rd_fn(rq[0].addr);
        end else begin
          r_valid = 1'b0;
          r_data  = '0;
        end
        b_valid = (b_pend > 0);
        b_resp  = (b_pend > 0 && beat_b == err_beat) ? 2'b10 : 2'b00;

        if (ar_valid && ar_ready) begin
          if (exp_ar.size() > 0)
            chk("ar_addr", 64'(ar_addr), 64'(exp_ar.pop_front()));
          else
            chk("ar_extra", 64'(exp_ar.size()), 64'(1));
          if (first_ar_pend) begin
            first_ar = ar_addr;
            first_ar_pend = 0;
          end
          rq.push_back('{addr: ar_addr, due: cyc + rd_lat});
          n_ar++;
        end
        if (r_valid && r_ready) begin
          void'(rq.pop_front());
          if (first_r) begin
            chk_aw_next = 1;
            first_r = 0;
          end
        end
        if (aw_valid && aw_ready) begin
          if (exp_aw.size() > 0)
            chk("aw_addr", 64'(aw_addr), 64'(exp_aw.pop_front()));
          else
            chk("aw_extra", 64'(exp_aw.size()), 64'(1));
          n_aw++;
          aw_got = 1;
        end
        if (w_valid && w_ready) begin
          if (exp_w.size() > 0)
            chk("w_data", 64'(w_data), 64'(exp_w.pop_front()));
          else
            chk("w_extra", 64'(exp_w.size()), 64'(1));
          n_w++;
          w_got = 1;
        end
        if (aw_got && w_got) begin
          b_pend++;
          aw_got = 0;
          w_got = 0;
        end
        if (b_valid && b_ready) begin
          b_pend--;
          n_b++;
          if (beat_b == err_beat) chk_err_next = 1;
          beat_b++;
        end
        hold_ar = ar_valid && !ar_ready; hold_ar_a = ar_addr;
        hold_aw = aw_valid && !aw_ready; hold_aw_a = aw_addr;
        hold_w  = w_valid && !w_ready;   hold_w_d  = w_data;
      end
    end
  end

  task automatic start_job(
    input int hs, input int vs,
    input int sx, input int sy, input int dx, input int dy,
    input logic [31:0] sb, input logic [31:0] db,
    input logic [31:0] sp, input logic [31:0] dp,
    input int bp, input int lat, input int eb, input int dbl);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    for (int y = 0; y < vs; y++)
      for (int x = 0; x < hs; x++) begin
        exp_ar.push_back(ref_addr(sb, sp, sx, sy, x, y));
        exp_aw.push_back(ref_addr(db, dp, dx, dy, x, y));
        exp_w.push_back(rd_fn(ref_addr(sb, sp, sx, sy, x, y)));
      end
    bp_en = bp; rd_lat = lat; err_beat = eb; beat_b = 0;
    job_err = (eb >= 0 && eb < hs * vs) ? 1 : 0;
    first_r = 1; first_ar_pend = 1; d0 = done_cnt;
    hsize = DIMW'(hs); vsize = DIMW'(vs);
    src_minx = DIMW'(sx); src_miny = DIMW'(sy);
    dst_minx = DIMW'(dx); dst_miny = DIMW'(dy);
    src_baddr = sb; dst_baddr = db;
    src_pitch = sp; dst_pitch = dp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 64'(busy), 64'(1));
    chk("ar_lat", 64'(ar_valid), 64'(1));
    chk("err_clr", 64'(err), 64'(0));
    if (dbl != 0) begin
      start = 1'b1;
      hsize = hsize + DIMW'(1);
      src_baddr = sb ^ 32'h0000_1000;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_job();
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("job_done", 64'(done_cnt != d0), 64'(1));
    repeat (2) @(negedge clk);
    chk("one_done", 64'(done_cnt - d0), 64'(1));
    chk("ar_left", 64'(exp_ar.size()), 64'(0));
    chk("aw_left", 64'(exp_aw.size()), 64'(0));
    chk("w_left", 64'(exp_w.size()), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
    chk("err_end", 64'(err), 64'(job_err));
  endtask

  initial begin
    int hs, vs, sx, sy, dx, dy, eb;
    logic [31:0] sb, db, sp, dp;
    PoR_rst_n = 1'b0; start = 1'b0;
    hsize = '0; vsize = '0;
    src_minx = '0; src_miny = '0; dst_minx = '0; dst_miny = '0;
    src_baddr = '0; dst_baddr = '0; src_pitch = '0; dst_pitch = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'({busy, done, err, ar_valid, aw_valid,
                        w_valid, r_ready, b_ready}), 64'(0));
    PoR_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic copy, zero-wait slave
    start_job(4, 2, 0, 0, 0, 0, 32'h0010_0000, 32'h0020_0000,
              32'h40, 32'h40, 0, 1, -1, 0);
    finish_job();
    chk("basic_first", 64'(first_ar), 64'(32'h0010_0000));
    chk("prot_strb", 64'({ar_prot, aw_prot, w_strb}),
        64'({6'b0, 4'hF}));

    // backpressure with 10-cycle read latency
    start_job(4, 2, 0, 0, 0, 0, 32'h0010_0000, 32'h0020_0000,
              32'h40, 32'h40, 1, 10, -1, 0);
    finish_job();

    // offset plus address wrap
    start_job(2, 2, 3, 2, 1, 1, 32'hFFFF_FF00, 32'h0030_0000,
              32'h100, 32'h100, 1, 3, -1, 0);
    finish_job();
    chk("wrap_first", 64'(first_ar), 64'(32'h0000_010C));

    // write error on the third beat
    start_job(4, 2, 0, 0, 0, 0, 32'h0010_0000, 32'h0020_0000,
              32'h40, 32'h40, 1, 2, 2, 0);
    finish_job();

    // zero size: next start clears err, done without traffic
    d0 = done_cnt;
    hsize = '0; vsize = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_quiet", 64'({busy, err, ar_valid, aw_valid, w_valid}),
        64'(0));
    @(negedge clk);
    chk("zero_pulse", 64'(done), 64'(0));

    // start while busy is ignored
    start_job(3, 2, 1, 0, 0, 1, 32'h0004_0000, 32'h0008_0000,
              32'h80, 32'h20, 1, 4, -1, 1);
    finish_job();

    // reset mid-run abandons the job
    start_job(4, 3, 0, 0, 0, 0, 32'h0010_0000, 32'h0020_0000,
              32'h40, 32'h40, 0, 3, -1, 0);
    repeat (4) @(negedge clk);
    #2 PoR_rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({busy, done, ar_valid, aw_valid,
                        w_valid, r_ready, b_ready}), 64'(0));
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    PoR_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    start_job(4, 2, 0, 0, 0, 0, 32'h0010_0000, 32'h0020_0000,
              32'h40, 32'h40, 0, 1, -1, 0);
    finish_job();

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      hs = $urandom_range(1, 6);
      vs = $urandom_range(1, 4);
      sx = $urandom_range(0, 20);
      sy = $urandom_range(0, 20);
      dx = $urandom_range(0, 20);
      dy = $urandom_range(0, 20);
      sb = $urandom() & 32'hFFFF_FFFC;
      db = $urandom() & 32'hFFFF_FFFC;
      sp = 32'($urandom_range(1, 256)) * 32'd4;
      dp = 32'($urandom_range(1, 256)) * 32'd4;
      eb = ($urandom_range(0, 2) == 0) ?
           $urandom_range(0, hs * vs - 1) : -1;
      start_job(hs, vs, sx, sy, dx, dy, sb, db, sp, dp,
                $urandom_range(0, 1), $urandom_range(1, 8), eb, 0);
      finish_job();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mst_imp_dma.md
MST_IMP_DMA -- requirements
Module: mst_imp_dma

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, AXI-Lite address width; DATA_W, default 32, data width (32 or 64); FIFO_DEPTH, default 8, read-to-write buffer depth (power of 2, at least 2); DIM_W, default 8, width of size and coordinate fields.
REQ-002 Clock and reset SHALL be: clk input 1, single clock; PoR_rst_n input 1, asynchronous active-low reset.
REQ-003 Control inputs SHALL be: start input 1, single-cycle go pulse; hsize and vsize input DIM_W, rectangle size in beats and rows; src_minx, src_miny, dst_minx, dst_miny input DIM_W, rectangle origin in beats and rows.
REQ-004 Address inputs SHALL be: src_baddr, dst_baddr, src_pitch, dst_pitch input ADDR_W; pitch is the row stride in bytes.
REQ-005 Status outputs SHALL be: busy output 1, transfer in progress; done output 1, one-cycle completion pulse; err output 1, sticky response error flag.
REQ-006 The read channel SHALL be: ar_valid out 1, ar_ready in 1, ar_addr out ADDR_W, ar_prot out 3, r_valid in 1, r_ready out 1, r_data in DATA_W, r_resp in 2.
REQ-007 The write channel SHALL be: aw_valid out 1, aw_ready in 1, aw_addr out ADDR_W, aw_prot out 3, w_valid out 1, w_ready in 1, w_data out DATA_W, w_strb out DATA_W/8, b_valid in 1, b_ready out 1, b_resp in 2.

Function
REQ-008 The FSM SHALL have states IDLE, RUN and FLUSH; IDLE goes to RUN on start, RUN goes to FLUSH when the last AR has been accepted, and FLUSH goes to IDLE when the last B has been accepted.
REQ-009 start SHALL be ignored while busy=1; all configuration inputs SHALL be latched on the accepted start cycle.
REQ-010 When hsize=0 or vsize=0, the block SHALL issue no transactions and SHALL pulse done in the cycle after start, with busy staying 0.
REQ-011 Read beat (x,y) SHALL address src_baddr + (src_miny+y)*src_pitch + (src_minx+x)*(DATA_W/8), computed modulo 2^ADDR_W; write beats SHALL use the dst_* fields in the same way.
REQ-012 Beat order SHALL be raster: x from 0 to hsize-1 inside y from 0 to vsize-1; x SHALL wrap to 0 and y SHALL increment on the last beat of a row.
REQ-013 ar_valid SHALL assert only when the FIFO occupancy plus reads in flight is less than FIFO_DEPTH, so r_ready=1 is held constantly while busy.
REQ-014 Once asserted, ar_valid, aw_valid and w_valid SHALL hold with stable address and data until their handshake completes.
REQ-015 The write side SHALL pop one FIFO entry per beat and assert aw_valid and w_valid in the same cycle; each handshake SHALL complete independently, and the next beat SHALL not start before b_valid&b_ready.
REQ-016 b_ready SHALL be 1 whenever a write response is outstanding; there SHALL be at most one write in flight.
REQ-017 w_strb SHALL be all ones, and ar_prot and aw_prot SHALL be 3'b000.
REQ-018 A simultaneous FIFO push (r handshake) and pop SHALL leave the occupancy unchanged; the FIFO SHALL never overflow or underflow.
REQ-019 err SHALL set on any r_resp or b_resp not equal to 2'b00, SHALL clear on an accepted start, and SHALL not abort the transfer.
REQ-020 done SHALL pulse for one cycle in the cycle after the final B handshake, and busy SHALL deassert in that same cycle.
REQ-021 Latency SHALL be: ar_valid rises one cycle after the accepted start, and the first aw_valid rises one cycle after the first r handshake.

Reset
REQ-022 PoR_rst_n low SHALL asynchronously force IDLE, empty the FIFO, clear all counters, and drive busy, done, err and every valid/ready output to 0.
REQ-023 A reset during RUN or FLUSH SHALL abandon the transfer without a done pulse; after reset release the block SHALL accept a new start.

Verification
REQ-024 Basic copy: hsize=4, vsize=2, minx=miny=0, src 0x0010_0000, dst 0x0020_0000, pitches 0x40, zero-wait slave -> AR addresses 0x100000/04/08/0C/40/44/48/4C, matching AW addresses at 0x2000xx, data preserved, one done pulse, err=0.
REQ-025 Backpressure: same job with ar_ready, aw_ready and w_ready randomly low and read latency of 10 cycles with FIFO_DEPTH=2 -> reads in flight plus occupancy never exceed 2, 8 beats written in order, and valids stay stable while stalled.
REQ-026 Offset and wrap: src_minx=3, src_miny=2, pitch 0x100, src_baddr 0xFFFF_FF00 -> first ar_addr 0x0000_010C (wrapped), with row steps of 0x100.
REQ-027 Error: b_resp=2'b10 on beat 3 of 8 -> err=1 from the following cycle, all 8 beats still written, done pulses, and the next start clears err.
REQ-028 Zero size and restart: hsize=0 -> done one cycle after start with no valids; a second start while busy is ignored; PoR_rst_n pulsed mid-RUN -> all valids 0 at once, no done pulse, and a new job completes normally.
